// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW bundle fetch/issue control path.
// Pure declarations: no logic, no latency, no flow control.
// Used by fetch_sequencer and its helpers.
package vliw_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        EXEC,
        HALT
    } fetch_state_t;

    localparam int SLOT_WIDTH = 32;

    // Byte-offset bits that must be zero in a bundle address (NFU a power of two).
    function automatic logic [63:0] align_mask(input int nfu);
        return 64'(nfu * (SLOT_WIDTH / 8)) - 64'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_branch_select.sv
// Priority encoder over per-FU branch requests; lowest-index FU wins. Optional conflict flag under BRANCH_CONFLICT_CHECK_EN.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a result is consumed.
module branch_select #(
    parameter int NFU = 8
) (
    input  logic [NFU-1:0] writePC,
    input  logic [63:0]    newPC [NFU],
    output logic           valid,
    output logic [63:0]    target,
    output logic           conflict
);

`ifdef BRANCH_CONFLICT_CHECK_EN
    localparam bit CONFLICT_EN = 1'b1;
`else
    localparam bit CONFLICT_EN = 1'b0;
`endif

    always_comb begin
        valid    = 1'b0;
        target   = '0;
        conflict = 1'b0;
        for (int i = 0; i < NFU; i++) begin
            if (writePC[i]) begin
                if (!valid) begin
                    valid  = 1'b1;
                    target = newPC[i];
                end else if (CONFLICT_EN && (newPC[i] != target)) begin
                    conflict = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Bundle sequencer: owns the PC, fetches bundles from the MMU, issues them to all FUs, picks the next PC. Macro: BRANCH_CONFLICT_CHECK_EN.
// Latency: issue strobe the cycle after MMU done; 4-cycle bundle period with a 1-cycle MMU and idle FUs.
// Backpressure: waits indefinitely on MMU done and on fuWorking; all outputs registered.
module fetch_sequencer
    import vliw_pkg::*;
#(
    parameter int          NFU                  = 8,
    parameter logic [63:0] RESET_VECTOR         = 64'h0,
    localparam int         INSTRUCTIONSIZEBYTES = NFU * (SLOT_WIDTH / 8),
    localparam int         INSTRUCTIONSIZE      = INSTRUCTIONSIZEBYTES * 8
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       doInstructionFetch,
    output logic [63:0]                instructionAddress,
    input  logic                       doneInstructionFetch,
    input  logic [INSTRUCTIONSIZE-1:0] instructionIn,
    output logic [INSTRUCTIONSIZE-1:0] instruction,
    output logic [63:0]                bundleAddr,
    output logic                       instructionReady,
    input  logic [NFU-1:0]             fuWorking,
    input  logic [63:0]                newPC [NFU],
    input  logic [NFU-1:0]             writePC,
    output logic                       fault
);

    localparam logic [63:0] SEQ_STEP   = 64'(INSTRUCTIONSIZEBYTES);
    localparam logic [63:0] ALIGN_MASK = align_mask(NFU);

    fetch_state_t               state_q, state_d;
    logic [63:0]                pc_q, pc_d;
    logic [63:0]                tgt_q, tgt_d;
    logic                       pend_q, pend_d;
    logic                       fetch_q, fetch_d;
    logic                       ready_q, ready_d;
    logic                       fault_q, fault_d;
    logic [INSTRUCTIONSIZE-1:0] instr_q, instr_d;
    logic [63:0]                baddr_q, baddr_d;

    logic        bs_valid;
    logic [63:0] bs_target;
    logic        bs_conflict;
    logic        take_branch;
    logic [63:0] next_pc;

    branch_select #(
        .NFU (NFU)
    ) u_branch_select (
        .writePC  (writePC),
        .newPC    (newPC),
        .valid    (bs_valid),
        .target   (bs_target),
        .conflict (bs_conflict)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        pend_d      = pend_q;
        fetch_d     = 1'b0;
        ready_d     = 1'b0;
        fault_d     = fault_q;
        instr_d     = instr_q;
        baddr_d     = baddr_q;
        take_branch = (state_q == EXEC) && !pend_q && bs_valid;
        next_pc     = pc_q + SEQ_STEP;

        case (state_q)
            FETCH: begin
                // Out of reset the strobe register is low, so spend one cycle raising it.
                if (fetch_q) begin
                    state_d = WAIT;
                end else begin
                    fetch_d = 1'b1;
                end
            end
            WAIT: begin
                if (doneInstructionFetch) begin
                    instr_d = instructionIn;
                    baddr_d = pc_q;
                    ready_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (take_branch) begin
                    pend_d = 1'b1;
                    tgt_d  = bs_target;
                end
                if (take_branch && bs_conflict) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end else if (!ready_q && (fuWorking == '0)) begin
                    if (pend_q) begin
                        next_pc = tgt_q;
                    end else if (take_branch) begin
                        next_pc = bs_target;
                    end
                    pend_d = 1'b0;
                    if ((next_pc & ALIGN_MASK) != 64'd0) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        fetch_d = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
            fetch_q <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            instr_q <= '0;
            baddr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
            fetch_q <= fetch_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            instr_q <= instr_d;
            baddr_q <= baddr_d;
        end
    end

    assign doInstructionFetch = fetch_q;
    assign instructionAddress = pc_q;
    assign instruction        = instr_q;
    assign bundleAddr         = baddr_q;
    assign instructionReady   = ready_q;
    assign fault              = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected fetches/issues, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam int NFU = 8;
    localparam int IW  = NFU * 32;

    typedef struct {
        logic [63:0]   addr;
        logic [IW-1:0] data;
    } iss_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          doInstructionFetch;
    logic [63:0]   instructionAddress;
    logic          doneInstructionFetch;
    logic [IW-1:0] instructionIn;
    logic [IW-1:0] instruction;
    logic [63:0]   bundleAddr;
    logic          instructionReady;
    logic [NFU-1:0] fuWorking;
    logic [63:0]   newPC [NFU];
    logic [NFU-1:0] writePC;
    logic          fault;

    fetch_sequencer #(
        .NFU          (NFU),
        .RESET_VECTOR (64'h0)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .doInstructionFetch   (doInstructionFetch),
        .instructionAddress   (instructionAddress),
        .doneInstructionFetch (doneInstructionFetch),
        .instructionIn        (instructionIn),
        .instruction          (instruction),
        .bundleAddr           (bundleAddr),
        .instructionReady     (instructionReady),
        .fuWorking            (fuWorking),
        .newPC                (newPC),
        .writePC              (writePC),
        .fault                (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_fetch [$];
    iss_t        exp_issue [$];

    task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: every fetch strobe and issue strobe must match a queued expectation.
    iss_t mon_e;
    always @(negedge clk) begin
        if (doInstructionFetch) begin
            if (exp_fetch.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_fetch: got addr %0h, none expected", instructionAddress);
            end else begin
                chk("fetch_addr", IW'(instructionAddress), IW'(exp_fetch.pop_front()));
            end
        end
        if (instructionReady) begin
            if (exp_issue.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_issue: got bundleAddr %0h, none expected", bundleAddr);
            end else begin
                mon_e = exp_issue.pop_front();
                chk("issue_addr", IW'(bundleAddr), IW'(mon_e.addr));
                chk("issue_data", instruction, mon_e.data);
            end
        end
    end

    task automatic fu_idle();
        fuWorking = '0;
        writePC   = '0;
        for (int i = 0; i < NFU; i++) newPC[i] = 64'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        doneInstructionFetch = 1'b0;
        instructionIn = '0;
        fu_idle();
        tick();
        tick();
        chk("rst_fetch", IW'(doInstructionFetch), IW'(0));
        chk("rst_ready", IW'(instructionReady), IW'(0));
        chk("rst_fault", IW'(fault), IW'(0));
        chk("rst_instr", instruction, '0);
        chk("rst_baddr", IW'(bundleAddr), IW'(0));
        chk("rst_pc", IW'(instructionAddress), IW'(0));
        rst = 1'b0;
    endtask

    task automatic expect_fetch(input logic [63:0] a, output int fc);
        bit seen;
        seen = 1'b0;
        exp_fetch.push_back(a);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (doInstructionFetch) seen = 1'b1;
        end
        fc = cyc;
        if (!seen) begin
            n_checks++;
            $display("FAIL fetch_timeout: no fetch of %0h within 50 cycles", a);
        end
    endtask

    // MMU model: answer a fetch after dly extra wait cycles; returns in the issue cycle (posedge+1).
    task automatic serve(input logic [63:0] a, input int dly, input logic [IW-1:0] d, output int fc);
        iss_t e;
        expect_fetch(a, fc);
        e.addr = a;
        e.data = d;
        exp_issue.push_back(e);
        tick();
        repeat (dly) tick();
        doneInstructionFetch = 1'b1;
        instructionIn = d;
        tick();
        doneInstructionFetch = 1'b0;
        instructionIn = '0;
        chk("issue_strobe", IW'(instructionReady), IW'(1));
    endtask

    function automatic logic [IW-1:0] bundle(input logic [31:0] w);
        return {NFU{w}};
    endfunction

    int f0, f1, f2, f3, f4, f5, low_cyc;

    initial begin
        rst = 1'b1;
        doneInstructionFetch = 1'b0;
        instructionIn = '0;
        fu_idle();

        // Sequential flow, 2-cycle then 1-cycle MMU.
        do_reset();
        serve(64'h0,  1, bundle(32'hA000_0001), f0);
        serve(64'h20, 1, bundle(32'hA000_0002), f1);
        chk("period_mmu2", IW'(f1 - f0), IW'(5));
        serve(64'h40, 1, bundle(32'hA000_0003), f2);
        serve(64'h60, 0, bundle(32'hA000_0004), f3);
        chk("period_mmu2b", IW'(f3 - f2), IW'(5));
        serve(64'h80, 0, bundle(32'hA000_0005), f4);
        chk("period_min", IW'(f4 - f3), IW'(4));
        expect_fetch(64'hA0, f5);
        chk("period_min2", IW'(f5 - f4), IW'(4));

        // First branch wins; a later one in the same bundle is ignored.
        do_reset();
        serve(64'h0, 0, bundle(32'hB000_0001), f0);
        fuWorking = '1;
        writePC = 8'b0000_1000;
        newPC[3] = 64'h1000;
        tick();
        writePC = 8'b0000_0010;
        newPC[1] = 64'h2000;
        tick();
        fu_idle();
        serve(64'h1000, 0, bundle(32'hB000_0002), f1);
        expect_fetch(64'h1020, f2);

        // Simultaneous differing branches.
        do_reset();
        serve(64'h0, 0, bundle(32'hC000_0001), f0);
        writePC = 8'b0010_0100;
        newPC[2] = 64'h100;
        newPC[5] = 64'h200;
        tick();
        fu_idle();
`ifdef BRANCH_CONFLICT_CHECK_EN
        repeat (10) tick();
        chk("conflict_fault", IW'(fault), IW'(1));
`else
        expect_fetch(64'h100, f1);
        chk("no_conflict_fault", IW'(fault), IW'(0));
`endif

        // Misaligned target halts; reset recovers.
        do_reset();
        serve(64'h0, 0, bundle(32'hD000_0001), f0);
        writePC = 8'b0000_0001;
        newPC[0] = 64'h1004;
        tick();
        fu_idle();
        repeat (10) tick();
        chk("misalign_fault", IW'(fault), IW'(1));
        chk("halt_no_issue", IW'(instructionReady), IW'(0));
        do_reset();
        expect_fetch(64'h0, f0);

        // Busy FUs delay retire; PC wraps to zero.
        do_reset();
        serve(64'h0, 0, bundle(32'hE000_0001), f0);
        writePC = 8'b1000_0000;
        newPC[7] = 64'hFFFF_FFFF_FFFF_FFE0;
        tick();
        fu_idle();
        serve(64'hFFFF_FFFF_FFFF_FFE0, 0, bundle(32'hE000_0002), f1);
        fuWorking = 8'b0001_0000;
        repeat (10) tick();
        fuWorking = '0;
        low_cyc = cyc;
        expect_fetch(64'h0, f2);
        chk("fetch_after_busy", IW'(f2), IW'(low_cyc + 1));

        // Reset in WAIT coinciding with done: bundle dropped.
        do_reset();
        expect_fetch(64'h0, f0);
        tick();
        rst = 1'b1;
        doneInstructionFetch = 1'b1;
        instructionIn = bundle(32'hF000_0001);
        tick();
        rst = 1'b0;
        doneInstructionFetch = 1'b0;
        instructionIn = '0;
        chk("rst_done_instr", instruction, '0);
        chk("rst_done_ready", IW'(instructionReady), IW'(0));
        expect_fetch(64'h0, f1);
        chk("rst_done_instr2", instruction, '0);
        repeat (5) tick();

        chk("fetch_queue_empty", IW'(exp_fetch.size()), IW'(0));
        chk("issue_queue_empty", IW'(exp_issue.size()), IW'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Bundle sequencer between the MMU fetch port and the functional-unit array. Owns the program counter, requests bundle fetches from the MMU, latches the returned bundle and issues it to all FUs. Waits for the FUs to retire it, then selects the next PC from sequential flow or FU branch requests. It replaces the ad-hoc PC/fetch/execute control in the core top level.

## Interface
Parameters:
- NFU, 8, number of functional units; bundle is NFU 32-bit slots.
- RESET_VECTOR, 64'h0, address of the first bundle fetched after reset.
- INSTRUCTIONSIZEBYTES, localparam NFU*4.
- INSTRUCTIONSIZE, localparam INSTRUCTIONSIZEBYTES*8.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- doInstructionFetch  out  1  one-cycle fetch request to MMU.
- instructionAddress  out  64  bundle address; stable from request until done.
- doneInstructionFetch  in  1  MMU one-cycle completion strobe.
- instructionIn  in  INSTRUCTIONSIZE  bundle from MMU; valid when done=1.
- instruction  out  INSTRUCTIONSIZE  latched bundle; slot n = [32n+:32].
- bundleAddr  out  64  address of the bundle in `instruction`.
- instructionReady  out  1  one-cycle issue strobe to all FUs.
- fuWorking  in  NFU  per-FU busy.
- newPC  in  NFU×64  per-FU branch target (unpacked array).
- writePC  in  NFU  per-FU branch request, qualifies newPC.
- fault  out  1  sticky: misaligned target (or conflict, see Configuration).

## Operation
- States: FETCH, WAIT, EXEC, HALT (enum in package).
- Reset: state FETCH; pc=RESET_VECTOR; instruction=0; bundleAddr=0; doInstructionFetch=0; instructionReady=0; fault=0; branch-pending clear.
- FETCH: assert doInstructionFetch for one cycle with instructionAddress=pc, then go to WAIT.
- WAIT: hold address. On doneInstructionFetch, latch instruction<=instructionIn and bundleAddr<=pc, pulse instructionReady, then go to EXEC. The done strobe is ignored in every other state.
- EXEC, branch capture: sampled every EXEC cycle, including the cycle instructionReady is high.
  - The first cycle with writePC!=0 captures the target of the lowest-index asserting FU.
  - Any later requests for the same bundle are ignored.
- EXEC, retire: bundle retires on the first cycle, at least one cycle after the instructionReady cycle, with fuWorking==0. A branch presented on the retire cycle itself is still captured.
- Next PC on retire: the captured target if pending, else pc+INSTRUCTIONSIZEBYTES (64-bit, wraps modulo 2^64). Then clear pending and go to FETCH.
- Alignment: a target with nonzero bits below log2(INSTRUCTIONSIZEBYTES) sets fault and enters HALT instead of FETCH.
- HALT: no requests and no issue; outputs hold. Exit only via rst.
- rst mid-fetch or mid-execute: immediate return to reset values. A done strobe arriving in the reset cycle is dropped.

## Timing
- Request to issue: instructionReady is high the cycle after doneInstructionFetch.
- Minimum bundle period with 1-cycle MMU and FUs idle (fetch to next fetch):
  - FETCH (1), WAIT (≥1), EXEC issue cycle (1), retire cycle (1).
  - Total 4 cycles.
- Retire to next fetch: doInstructionFetch is high the cycle after the retire cycle.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- BRANCH_CONFLICT_CHECK_EN defined: two or more FUs assert writePC in the same cycle with differing newPC → fault=1, HALT. Identical targets are legal.
- Undefined: lowest-index FU wins silently; fault only on misalignment.

## Structure
- vliw_pkg holds:
  - fetch_state_t enum.
  - Bundle slot width constant (32).
  - Function returning alignment mask for a given NFU.
- Sub-module branch_select: combinational priority encoder over writePC/newPC. Outputs valid, target and conflict, with the conflict logic under the macro. Instantiated once.

## Test plan
- Reset then MMU done after 2 cycles, FUs idle → fetches at 0x0, 0x20, 0x40 (NFU=8); instructionReady once per bundle; bundleAddr matches.
- FU3 writePC newPC=0x1000 during EXEC, FU1 later same bundle newPC=0x2000 → next fetch 0x1000.
- FU2 and FU5 simultaneous, targets 0x100/0x200 → macro off: fetch 0x100; macro on: fault=1, no further doInstructionFetch.
- Target 0x1004 → fault=1, HALT; rst clears fault and refetches RESET_VECTOR.
- fuWorking held high 10 cycles after issue → no fetch until the cycle after fuWorking falls; pc wraps 0xFFFF_FFFF_FFFF_FFE0 → 0x0.
- rst asserted in WAIT with done in the same cycle → instruction stays 0, no instructionReady, fetch restarts at RESET_VECTOR.
